// File: rtl/semaforo_ctrl.sv
// Demand-driven two-road intersection controller sharing the semaforo lamp encoding.
// Pedestrian WALK phase is included only when SEMAFORO_PED_EN is defined.
module semaforo_ctrl #(
  parameter int T_CLEAR     = 3,
  parameter int T_MIN_GREEN = 6,
  parameter int T_GREEN     = 15,
  parameter int T_YELLOW    = 10,
  parameter int T_WALK      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       ped_req,
  output logic [7:0] luces,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase,
  output logic [7:0] contador
);

  localparam logic [2:0] S_CLR_A = 3'd0;
  localparam logic [2:0] S_GRN_A = 3'd1;
  localparam logic [2:0] S_YEL_A = 3'd2;
  localparam logic [2:0] S_CLR_B = 3'd3;
  localparam logic [2:0] S_GRN_B = 3'd4;
  localparam logic [2:0] S_YEL_B = 3'd5;
  localparam logic [2:0] S_WALK  = 3'd6;

  localparam logic [7:0] D_CLEAR  = 8'(T_CLEAR - 1);
  localparam logic [7:0] D_MIN    = 8'(T_MIN_GREEN - 1);
  localparam logic [7:0] D_GREEN  = 8'(T_GREEN - 1);
  localparam logic [7:0] D_YELLOW = 8'(T_YELLOW - 1);
  localparam logic [7:0] D_WALK   = 8'(T_WALK - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] luces_q, luces_d;
  logic       pend_a_q, pend_a_d;
  logic       pend_b_q, pend_b_d;
  logic       pend_p_q, pend_p_d;
  logic       next_b_q, next_b_d;
  logic       walk_q, walk_d;
  logic       ack_q, ack_d;
  logic       chg;
  logic       in_green;

  function automatic logic [7:0] lamp_code(input logic [2:0] s);
    case (s)
      S_GRN_A: lamp_code = 8'b1000_0001;
      S_YEL_A: lamp_code = 8'b1000_0010;
      S_GRN_B: lamp_code = 8'b0010_0100;
      S_YEL_B: lamp_code = 8'b0100_0100;
      default: lamp_code = 8'b1000_0100;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    next_b_d = next_b_q;
    case (state_q)
      S_CLR_A: if (cnt_q == D_CLEAR) state_d = S_GRN_A;
      S_CLR_B: if (cnt_q == D_CLEAR) state_d = S_GRN_B;
      S_GRN_A:
        if ((pend_b_q || pend_p_q) &&
            ((cnt_q >= D_MIN && !req_a) || cnt_q >= D_GREEN)) state_d = S_YEL_A;
      S_GRN_B:
        if ((pend_a_q || pend_p_q) &&
            ((cnt_q >= D_MIN && !req_b) || cnt_q >= D_GREEN)) state_d = S_YEL_B;
      S_YEL_A:
        if (cnt_q == D_YELLOW) begin
          state_d  = pend_p_q ? S_WALK : S_CLR_B;
          next_b_d = 1'b1;
        end
      S_YEL_B:
        if (cnt_q == D_YELLOW) begin
          state_d  = pend_p_q ? S_WALK : S_CLR_A;
          next_b_d = 1'b0;
        end
      S_WALK: if (cnt_q == D_WALK) state_d = next_b_q ? S_CLR_B : S_CLR_A;
      default: state_d = S_CLR_A;
    endcase

    chg      = (state_d != state_q);
    in_green = (state_q == S_GRN_A) || (state_q == S_GRN_B);
    // Green with nothing pending rests at T_GREEN-1 instead of counting on.
    if (chg)                          cnt_d = 8'd0;
    else if (in_green && cnt_q >= D_GREEN) cnt_d = cnt_q;
    else                              cnt_d = cnt_q + 8'd1;

    // Entry clear beats a same-cycle set, so a request at entry is absorbed.
    pend_a_d = (chg && state_d == S_GRN_A) ? 1'b0 : (pend_a_q || (req_a && state_q != S_GRN_A));
    pend_b_d = (chg && state_d == S_GRN_B) ? 1'b0 : (pend_b_q || (req_b && state_q != S_GRN_B));
`ifdef SEMAFORO_PED_EN
    pend_p_d = (chg && state_d == S_WALK) ? 1'b0 : (pend_p_q || (ped_req && state_q != S_WALK));
    walk_d   = (state_d == S_WALK);
    ack_d    = chg && (state_d == S_WALK);
`else
    pend_p_d = 1'b0;
    walk_d   = 1'b0;
    ack_d    = 1'b0;
`endif
    luces_d  = lamp_code(state_d);
  end

`ifndef SEMAFORO_PED_EN
  logic unused_ped;
  assign unused_ped = ped_req;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_CLR_A;
      cnt_q    <= 8'd0;
      luces_q  <= 8'b1000_0100;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      pend_p_q <= 1'b0;
      next_b_q <= 1'b0;
      walk_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      luces_q  <= luces_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      pend_p_q <= pend_p_d;
      next_b_q <= next_b_d;
      walk_q   <= walk_d;
      ack_q    <= ack_d;
    end
  end

  assign luces    = luces_q;
  assign walk     = walk_q;
  assign ped_ack  = ack_q;
  assign phase    = state_q;
  assign contador = cnt_q;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Directed bench for semaforo_ctrl: cycle-run table plus hand sequences for resets,
// rest behaviour and the pedestrian rotation (when SEMAFORO_PED_EN is defined).
module tb_semaforo_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       req_a = 1'b0;
  logic       req_b = 1'b0;
  logic       ped_req = 1'b0;
  logic [7:0] luces;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;
  logic [7:0] contador;

  int n_cmp = 0;
  int n_bad = 0;

  semaforo_ctrl dut (
    .clock(clock), .reset(reset), .req_a(req_a), .req_b(req_b), .ped_req(ped_req),
    .luces(luces), .walk(walk), .ped_ack(ped_ack), .phase(phase), .contador(contador)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, ra, rb, pr;
    int         n;
    logic [2:0] ph;
    int         cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic ra, logic rb, logic pr, int n, logic [2:0] ph, int cnt);
    vec_t v;
    v.rst = rst; v.ra = ra; v.rb = rb; v.pr = pr; v.n = n; v.ph = ph; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [7:0] exp_luces(logic [2:0] ph);
    case (ph)
      3'd1: return 8'b1000_0001;
      3'd2: return 8'b1000_0010;
      3'd4: return 8'b0010_0100;
      3'd5: return 8'b0100_0100;
      default: return 8'b1000_0100;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_phase(input logic [2:0] target, input int max, output int cycles);
    cycles = 0;
    while (phase != target && cycles < max) begin
      step();
      cycles++;
    end
    if (phase != target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_phase_%0d: timeout after %0d cycles, phase %0d", target, max, phase);
    end
  endtask

  task automatic chk_state(input string name, input int ph, input int cnt);
    chk({name, "_phase"}, phase, ph);
    chk({name, "_cnt"}, contador, cnt);
    chk({name, "_luces"}, luces, exp_luces(3'(ph)));
  endtask

  logic [2:0] prev_ph;
  int cyc;

  initial begin
    tbl.push_back(mk(1, 0, 0, 0, 1, 3'd0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 3'd0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 15, 3'd1, 14));
    tbl.push_back(mk(0, 0, 0, 0, 5, 3'd1, 14));
    tbl.push_back(mk(0, 0, 1, 0, 1, 3'd1, 14));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'd2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 9, 3'd2, 9));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'd3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 3'd3, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'd4, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 3'd4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4, 3'd4, 5));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'd5, 0));
    tbl.push_back(mk(0, 0, 0, 0, 9, 3'd5, 9));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'd0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 3'd0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'd1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 3'd1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 3'd1, 2));
    tbl.push_back(mk(0, 1, 0, 0, 12, 3'd1, 14));
    tbl.push_back(mk(0, 1, 0, 0, 1, 3'd2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 9, 3'd2, 9));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'd3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 3'd3, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'd4, 0));
    tbl.push_back(mk(0, 0, 0, 0, 20, 3'd4, 14));
`ifdef SEMAFORO_PED_EN
    tbl.push_back(mk(0, 0, 0, 1, 1, 3'd4, 14));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'd5, 0));
    tbl.push_back(mk(0, 0, 0, 0, 9, 3'd5, 9));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'd6, 0));
    tbl.push_back(mk(0, 0, 0, 0, 7, 3'd6, 7));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'd0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 3'd0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'd1, 0));
`else
    tbl.push_back(mk(0, 0, 0, 1, 1, 3'd4, 14));
    tbl.push_back(mk(0, 0, 0, 1, 30, 3'd4, 14));
`endif

    prev_ph = 3'd0;
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        reset = tbl[i].rst; req_a = tbl[i].ra; req_b = tbl[i].rb; ped_req = tbl[i].pr;
        step();
        chk($sformatf("v%0d_phase", i), phase, tbl[i].ph);
        chk($sformatf("v%0d_luces", i), luces, exp_luces(tbl[i].ph));
        chk($sformatf("v%0d_walk", i), walk, (tbl[i].ph == 3'd6) ? 1 : 0);
        chk($sformatf("v%0d_ack", i), ped_ack,
            (tbl[i].ph == 3'd6 && prev_ph != 3'd6 && !tbl[i].rst) ? 1 : 0);
        prev_ph = tbl[i].ph;
      end
      chk($sformatf("v%0d_cnt", i), contador, tbl[i].cnt);
    end
    reset = 0; req_a = 0; req_b = 0; ped_req = 0;

`ifdef SEMAFORO_PED_EN
    // Pedestrian request from early GRN_A, then reset in the fourth WALK cycle.
    ped_req = 1; step(); ped_req = 0;
    wait_phase(3'd2, 20, cyc);
    chk("ped_grn_min_exit", cyc, 5);
    wait_phase(3'd6, 20, cyc);
    chk("ped_yel_len", cyc, 10);
    chk("ped_ack_first", ped_ack, 1);
    chk("ped_walk_on", walk, 1);
    step(); step(); step();
    chk("walk_cnt4", contador, 3);
    chk("ped_ack_later", ped_ack, 0);
    reset = 1; step(); reset = 0;
    chk_state("rst_walk", 0, 0);
    chk("rst_walk_walk", walk, 0);
    chk("rst_walk_ack", ped_ack, 0);
    for (int k = 0; k < 20; k++) step();
    chk_state("rst_walk_rest", 1, 14);

    // Both B and pedestrian pending: one rotation serves both.
    req_b = 1; ped_req = 1; step(); req_b = 0; ped_req = 0;
    wait_phase(3'd2, 5, cyc);
    chk("both_to_yel", cyc, 1);
    wait_phase(3'd6, 20, cyc);
    chk("both_yel_to_walk", cyc, 10);
    wait_phase(3'd3, 20, cyc);
    chk("both_walk_len", cyc, 8);
    wait_phase(3'd4, 10, cyc);
    chk("both_clr_b_len", cyc, 3);
    chk_state("both_grn_b", 4, 0);
`endif

    // Reset mid-yellow discards pending requests.
    reset = 1; step(); reset = 0;
    chk_state("rst_a", 0, 0);
    chk("rst_a_walk", walk, 0);
    chk("rst_a_ack", ped_ack, 0);
    wait_phase(3'd1, 10, cyc);
    chk("clr_a_len", cyc, 3);
    for (int k = 0; k < 15; k++) step();
    chk_state("rest_a", 1, 14);
    req_b = 1; step(); req_b = 0;
    wait_phase(3'd2, 5, cyc);
    chk("rest_exit", cyc, 1);
    step(); step(); step(); step();
    chk_state("yel_a_mid", 2, 4);
    reset = 1; step(); reset = 0;
    chk_state("rst_yel", 0, 0);
    for (int k = 0; k < 19; k++) step();
    chk_state("rst_yel_rest", 1, 14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
